// File: rtl/fc_layer_sequencer.sv
// Runs a chain of fully-connected layer engines one at a time over a shared memory,
// relocating each engine's accesses into its layer region and guarding each layer with a watchdog.
module fc_layer_sequencer #(
   parameter int unsigned NUM_LAYERS = 3,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned REGION     = 64,
   parameter int unsigned TIMEOUT    = 4096,
   parameter int unsigned CW         = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [NUM_LAYERS-1:0]      layer_end_i,
   input  logic [NUM_LAYERS-1:0]      layer_we_i,
   input  logic [NUM_LAYERS*16-1:0]   layer_addr_i,
   input  logic [NUM_LAYERS*16-1:0]   layer_out_i,
   output logic [NUM_LAYERS-1:0]      layer_en_o,
   output logic [NUM_LAYERS-1:0]      layer_rst_n_o,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_we,
   output logic [15:0]                mem_wdata,
   output logic [2:0]                 cur_layer,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   localparam int unsigned DW = 16;
   localparam int unsigned LW = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t                state, state_d;
   logic [LW-1:0]         cur_d;
   logic [CW-1:0]         wd, wd_d;
   logic [NUM_LAYERS-1:0] en_d, rst_n_d;
   logic                  busy_d, done_d, error_d;

   logic                  sel_end, sel_we;
   logic [DW-1:0]         sel_addr, sel_data;
   logic                  last_layer, expired;

   // Pick the signals of the engine addressed by cur_layer
   always_comb begin
      sel_end  = 1'b0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
         if (cur_layer == LW'(k)) begin
            sel_end  = layer_end_i[k];
            sel_we   = layer_we_i[k];
            sel_addr = layer_addr_i[DW*k +: DW];
            sel_data = layer_out_i[DW*k +: DW];
         end
      end
   end

   // Reads come from the layer's own region, writes go to the next layer's region
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == S_RUN) begin
         if (sel_we) begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'((32'(cur_layer) + 32'd1) * REGION + 32'(sel_addr));
            mem_wdata = sel_data;
         end else begin
            mem_addr  = ADDR_W'(32'(cur_layer) * REGION + 32'(sel_addr));
         end
      end
   end

   assign last_layer = (cur_layer == LW'(NUM_LAYERS - 1));
   assign expired    = (wd == CW'(TIMEOUT - 1));

   // Next state and next values of the registered outputs
   always_comb begin
      state_d = state;
      cur_d   = cur_layer;
      wd_d    = '0;
      busy_d  = busy;
      done_d  = 1'b0;
      error_d = error;
      en_d    = '0;
      rst_n_d = '1;

      case (state)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_d = S_CLR;
               cur_d   = '0;
               error_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_CLR: begin
            state_d = S_RUN;
            cur_d   = '0;
         end
         S_RUN: begin
            // A finishing engine wins over a simultaneous watchdog expiry
            if (sel_end) begin
               state_d = S_DRAIN;
            end else if (expired) begin
               state_d = S_ERR;
               error_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               wd_d = wd + CW'(1);
            end
         end
         S_DRAIN: begin
            if (last_layer) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = S_RUN;
               cur_d   = cur_layer + LW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (state_d == S_RUN) begin
         for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            en_d[k] = (cur_d == LW'(k));
         end
      end
      if (state_d == S_CLR) begin
         rst_n_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         cur_layer     <= '0;
         wd            <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         layer_en_o    <= '0;
         layer_rst_n_o <= '1;
      end else begin
         state         <= state_d;
         cur_layer     <= cur_d;
         wd            <= wd_d;
         busy          <= busy_d;
         done          <= done_d;
         error         <= error_d;
         layer_en_o    <= en_d;
         layer_rst_n_o <= rst_n_d;
      end
   end

endmodule
